// File: rtl/vga_text_reader_if.sv
// vga_text_reader_if: display-memory, font-ROM and video-output signals of the text reader.
interface vga_text_reader_if;
  logic [13:0] char_addr;
  logic [15:0] char_data_out;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        frame_start;
  modport master (
    output char_addr, font_addr, hsync, vsync, rgb, frame_start,
    input  char_data_out, font_data
  );
  modport slave (
    input  char_addr, font_addr, hsync, vsync, rgb, frame_start,
    output char_data_out, font_data
  );
endinterface

// File: rtl/vga_text_reader.sv
// vga_text_reader: 640x480@60 text-mode reader; walks the tile grid, expands glyphs, emits RGB and syncs.
module vga_text_reader #(
  parameter int COLS        = 80,
  parameter int ROWS        = 60,
  parameter int BLINK_SHIFT = 5
) (
  input  logic              clk,
  input  logic              reset,
  vga_text_reader_if.master bus
);
  localparam logic [9:0] H_VIS  = 10'(COLS * 8);
  localparam logic [9:0] H_TOT  = H_VIS + 10'd160;
  localparam logic [9:0] HS_BEG = H_VIS + 10'd16;
  localparam logic [9:0] HS_END = H_VIS + 10'd112;
  localparam logic [9:0] V_VIS  = 10'(ROWS * 8);
  localparam logic [9:0] V_TOT  = V_VIS + 10'd45;
  localparam logic [9:0] VS_BEG = V_VIS + 10'd10;
  localparam logic [9:0] VS_END = V_VIS + 10'd12;
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] hx;
    logic [2:0] vy;
  } pipe_t;
  localparam pipe_t PIPE_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, hx: 3'd0, vy: 3'd0};
  logic        r_pix_en;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [7:0]  r_frame_cnt;
  logic [13:0] r_char_addr;
  logic [10:0] r_font_addr;
  logic [15:0] r_tile;
  pipe_t       r_p1;
  pipe_t       r_p2;
  logic [2:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;
  pipe_t       w_p0;
  logic [13:0] w_addr;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_bit;
  logic [2:0]  w_fg;
  logic [2:0]  w_rgb;
  logic        w_unused;
  always_comb begin
    w_h_wrap = r_h == H_TOT - 10'd1;
    w_v_wrap = r_v == V_TOT - 10'd1;
    w_addr   = 14'(r_v[9:3]) * 14'(COLS) + 14'(r_h[9:3]);
    w_p0.vis = (r_h < H_VIS) && (r_v < V_VIS);
    w_p0.hs  = !((r_h >= HS_BEG) && (r_h < HS_END));
    w_p0.vs  = !((r_v >= VS_BEG) && (r_v < VS_END));
    w_p0.fs  = (r_h == '0) && (r_v == '0);
    w_p0.hx  = r_h[2:0];
    w_p0.vy  = r_v[2:0];
    // r_tile and font_data both belong to the pixel carried in r_p2 on this tick
    w_bit    = bus.font_data[3'd7 - r_p2.hx];
    w_fg     = (r_tile[15] && r_frame_cnt[BLINK_SHIFT]) ? r_tile[14:12] : r_tile[10:8];
    w_rgb    = !r_p2.vis ? 3'd0 : w_bit ? w_fg : r_tile[14:12];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_en      <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_frame_cnt   <= '0;
      r_char_addr   <= '0;
      r_font_addr   <= '0;
      r_tile        <= '0;
      r_p1          <= PIPE_IDLE;
      r_p2          <= PIPE_IDLE;
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_en      <= !r_pix_en;
      r_frame_start <= 1'b0;
      if (r_pix_en) begin
        r_h <= w_h_wrap ? '0 : r_h + 10'd1;
        if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + 10'd1;
        if (w_h_wrap && w_v_wrap) r_frame_cnt <= r_frame_cnt + 8'd1;
        if (w_p0.vis) r_char_addr <= w_addr;
        r_p1          <= w_p0;
        r_tile        <= bus.char_data_out;
        r_font_addr   <= {bus.char_data_out[7:0], r_p1.vy};
        r_p2          <= r_p1;
        r_rgb         <= w_rgb;
        r_hsync       <= r_p2.hs;
        r_vsync       <= r_p2.vs;
        r_frame_start <= r_p2.fs;
      end
    end
  end
  assign w_unused        = ^{r_tile[11], r_tile[7:0], r_frame_cnt, r_p2.vy};
  assign bus.char_addr   = r_char_addr;
  assign bus.font_addr   = r_font_addr;
  assign bus.rgb         = r_rgb;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_text_reader.sv
// tb_vga_text_reader: full-size and shrunken (4x2 tiles) readers against a pixel reference model and directed vectors.
module tb_vga_text_reader;
  typedef struct {
    bit          d;
    bit          is_addr;
    int          h;
    int          v;
    int          f;
    logic [13:0] addr;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
  } vec_t;
  localparam int NV    = 21;
  localparam int END_E = 46860;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] mem_a [0:16383];
  logic [15:0] mem_b [0:16383];
  logic [7:0]  font  [0:2047];
  vec_t vec [NV];
  always #10 clk = ~clk;
  vga_text_reader_if ifa ();
  vga_text_reader_if ifb ();
  vga_text_reader dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  vga_text_reader #(.COLS(4), .ROWS(2), .BLINK_SHIFT(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));
  always @(posedge clk) begin
    ifa.char_data_out <= mem_a[ifa.char_addr];
    ifa.font_data     <= font[ifa.font_addr];
    ifb.char_data_out <= mem_b[ifb.char_addr];
    ifb.font_data     <= font[ifb.font_addr];
  end
  always @(posedge clk or negedge reset) if (!reset) e <= 0; else e <= e + 1;
  // expected {rgb, hsync, vsync, frame_start} seen after clk edge ed counted from reset release
  function automatic logic [5:0] model(bit d, int ed);
    int ht = d ? 192 : 800;
    int vt = d ? 61 : 525;
    int hv = d ? 32 : 640;
    int vv = d ? 16 : 480;
    int cols = d ? 4 : 80;
    int k, h, v, f;
    logic [15:0] t;
    logic [7:0] g;
    logic [2:0] fg, bg;
    if (ed < 6) return 6'b000110;
    k = (ed - 6) / 2;
    h = k % ht;
    v = (k / ht) % vt;
    f = k / (ht * vt);
    t = d ? mem_b[(v / 8) * cols + h / 8] : mem_a[(v / 8) * cols + h / 8];
    g = font[{t[7:0], 3'(v % 8)}];
    bg = t[14:12];
    fg = (t[15] && f[d ? 0 : 5]) ? bg : t[10:8];
    return {(h < hv && v < vv) ? (g[7 - h % 8] ? fg : bg) : 3'b000,
            !(h >= hv + 16 && h < hv + 112), !(v >= vv + 10 && v < vv + 12),
            (ed % 2 == 0) && h == 0 && v == 0};
  endfunction
  function automatic int tgt(vec_t x);
    int ht = x.d ? 192 : 800;
    int vt = x.d ? 61 : 525;
    int k = (x.f * vt + x.v) * ht + x.h;
    return x.is_addr ? 2 + 2 * k : 6 + 2 * k;
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, e, got, exp);
    end
  endtask
  initial begin
    int idx, hf0, hf1, hr0, vf0, vf1, vr0, fs_first;
    logic prev_hs, prev_vs;
    vec[0]  = '{0, 0,   0,  0, 0, 14'd0,  3'b111, 1'b1, 1'b1};
    vec[1]  = '{1, 0,   0,  0, 0, 14'd0,  3'b100, 1'b1, 1'b1};
    vec[2]  = '{0, 0,   1,  0, 0, 14'd0,  3'b010, 1'b1, 1'b1};
    vec[3]  = '{0, 0,   6,  0, 0, 14'd0,  3'b010, 1'b1, 1'b1};
    vec[4]  = '{0, 0,   7,  0, 0, 14'd0,  3'b111, 1'b1, 1'b1};
    vec[5]  = '{1, 0,   7,  0, 0, 14'd0,  3'b100, 1'b1, 1'b1};
    vec[6]  = '{1, 0,  32,  0, 0, 14'd0,  3'b000, 1'b1, 1'b1};
    vec[7]  = '{0, 0, 640,  0, 0, 14'd0,  3'b000, 1'b1, 1'b1};
    vec[8]  = '{0, 0, 656,  0, 0, 14'd0,  3'b000, 1'b0, 1'b1};
    vec[9]  = '{0, 0, 751,  0, 0, 14'd0,  3'b000, 1'b0, 1'b1};
    vec[10] = '{0, 0, 752,  0, 0, 14'd0,  3'b000, 1'b1, 1'b1};
    vec[11] = '{1, 1,  31, 15, 0, 14'd7,  3'b000, 1'b1, 1'b1};
    vec[12] = '{1, 1, 100, 15, 0, 14'd7,  3'b000, 1'b1, 1'b1};
    vec[13] = '{1, 0,   0, 25, 0, 14'd0,  3'b000, 1'b1, 1'b1};
    vec[14] = '{1, 0,   0, 26, 0, 14'd0,  3'b000, 1'b1, 1'b0};
    vec[15] = '{1, 0,   0, 28, 0, 14'd0,  3'b000, 1'b1, 1'b1};
    vec[16] = '{0, 1, 639,  7, 0, 14'd79, 3'b000, 1'b1, 1'b1};
    vec[17] = '{0, 1, 700,  7, 0, 14'd79, 3'b000, 1'b1, 1'b1};
    vec[18] = '{0, 1,   8,  8, 0, 14'd81, 3'b000, 1'b1, 1'b1};
    vec[19] = '{1, 0,   0,  0, 1, 14'd0,  3'b010, 1'b1, 1'b1};
    vec[20] = '{1, 0,   3,  0, 1, 14'd0,  3'b010, 1'b1, 1'b1};
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    mem_a[0] = 16'h2741;
    mem_b[0] = 16'hA4FF;
    font[{8'h41, 3'd0}] = 8'h81;
    for (int r = 0; r < 8; r++) font[{8'hFF, 3'(r)}] = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("reset_a", {1'b0, ifa.char_addr, ifa.font_addr, ifa.rgb, ifa.hsync, ifa.vsync, ifa.frame_start}, 32'h6);
    check("reset_b", {1'b0, ifb.char_addr, ifb.font_addr, ifb.rgb, ifb.hsync, ifb.vsync, ifb.frame_start}, 32'h6);
    @(negedge clk) reset = 1'b1;
    idx = 0;
    hf0 = -1; hf1 = -1; hr0 = -1; vf0 = -1; vf1 = -1; vr0 = -1; fs_first = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    for (int c = 0; c < 60000 && e < END_E; c++) begin
      @(negedge clk);
      check("model_a", {26'd0, ifa.rgb, ifa.hsync, ifa.vsync, ifa.frame_start}, {26'd0, model(0, e)});
      check("model_b", {26'd0, ifb.rgb, ifb.hsync, ifb.vsync, ifb.frame_start}, {26'd0, model(1, e)});
      while (idx < NV && tgt(vec[idx]) <= e) begin
        if (vec[idx].is_addr)
          check($sformatf("vec%0d_addr", idx), {18'd0, vec[idx].d ? ifb.char_addr : ifa.char_addr}, {18'd0, vec[idx].addr});
        else
          check($sformatf("vec%0d_pix", idx),
                {27'd0, vec[idx].d ? {ifb.rgb, ifb.hsync, ifb.vsync} : {ifa.rgb, ifa.hsync, ifa.vsync}},
                {27'd0, vec[idx].rgb, vec[idx].hs, vec[idx].vs});
        idx++;
      end
      if (ifb.frame_start && fs_first < 0) fs_first = e;
      if (prev_hs && !ifa.hsync) begin if (hf0 < 0) hf0 = e; else if (hf1 < 0) hf1 = e; end
      if (!prev_hs && ifa.hsync && hf0 >= 0 && hr0 < 0) hr0 = e;
      if (prev_vs && !ifb.vsync) begin if (vf0 < 0) vf0 = e; else if (vf1 < 0) vf1 = e; end
      if (!prev_vs && ifb.vsync && vf0 >= 0 && vr0 < 0) vr0 = e;
      prev_hs = ifa.hsync;
      prev_vs = ifb.vsync;
    end
    check("vectors_applied", 32'(idx), NV);
    check("first_frame_start", 32'(fs_first), 32'd6);
    check("hsync_low_clk", 32'(hr0 - hf0), 32'd192);
    check("hsync_period_clk", 32'(hf1 - hf0), 32'd1600);
    check("vsync_low_clk", 32'(vr0 - vf0), 32'd768);
    check("vsync_period_clk", 32'(vf1 - vf0), 32'd23424);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_reader.md
# vga_text_reader

Read-side engine for the character display memory at 0xB00xxxxx. The CPU writes tiles into display memory through the data bus; this block is the other port's reader. It generates 640x480@60 VGA timing from the 50 MHz system clock and walks `char_addr` across the 80x60 tile grid. Each fetched 16-bit tile is expanded through an external 8x8 font ROM into 3-bit RGB pixels.

## Interface
Parameters:
- `COLS`, 80, tiles per row (8 px each)
- `ROWS`, 60, tile rows (8 lines each)
- `BLINK_SHIFT`, 5, frame-counter bit that drives blink (toggles every 32 frames)

Ports:
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-low reset
- `char_addr`  out  14  tile address into display memory port B
- `char_data_out`  in  16  tile from display memory; valid the clk after `char_addr`
- `font_addr`  out  11  font ROM address {char_code[7:0], glyph_row[2:0]}
- `font_data`  in  8  glyph row; valid the clk after `font_addr`; bit 7 = leftmost pixel
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `rgb`  out  3  pixel colour {R,G,B}; 0 during blanking
- `frame_start`  out  1  one-clk pulse on the pixel tick with h=0, v=0

## Operation
- Pixel tick:
  - `pix_en` toggles every clk and resets to 0.
  - All counters and pipeline stages advance only when `pix_en`=1, i.e. a 25 MHz tick.
  - The first tick is the second clk edge after `reset` deasserts.
- Horizontal counter `h`, 0..799:
  - visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
  - Wraps to 0 and increments `v`.
- Vertical counter `v`, 0..524:
  - visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
  - Wraps to 0 and increments an 8-bit `frame_cnt`.
- Stage 0, on the tick at position (h,v):
  - `char_addr` = (v>>3)*COLS + (h>>3), computed with width-exact 14-bit arithmetic.
  - Outside the visible area `char_addr` holds its last value.
- Stage 1, next tick: latch `char_data_out` into `tile`, then drive `font_addr` = {tile[7:0], v_d1[2:0]}.
- Stage 2, next tick: latch `font_data`, then select bit (7 − h_d2[2:0]).
- Tile format:
  - [7:0] char code
  - [10:8] fg RGB
  - [11] reserved, ignored
  - [14:12] bg RGB
  - [15] blink
- Pixel colour:
  - glyph bit = 1 → fg
  - glyph bit = 0 → bg
  - If blink=1 and `frame_cnt[BLINK_SHIFT]`=1, fg is replaced by bg.
- Syncs: `hsync`, `vsync`, the visible flag, h[2:0] and v[2:0] are delayed through the same 2-tick pipe so output stays aligned.

## Timing
- Reset values (all outputs registered):
  - `hsync`=1, `vsync`=1, `rgb`=0, `frame_start`=0
  - `char_addr`=0, `font_addr`=0
  - h=v=0, `frame_cnt`=0, pipe valid flags=0
- Latency: the `rgb`/`hsync`/`vsync` value for position (h,v) appears 2 pixel ticks (4 clk) after the tick that issued `char_addr` for it.
- Memory handshake: none.
  - Display memory and font ROM are fixed 1-clk synchronous reads.
  - Each has one spare clk before the consuming tick.
- Line period is 1600 clk; `hsync` low for 192 clk.
- Frame period is 840 000 clk; `vsync` low for 2 lines (3200 clk).
- Boundary conditions:
  - Last visible pixel is (639,479), giving `char_addr` = 59*80+79 = 4799.
  - The h wrap at 799 and the v wrap at 524 occur on the same tick and produce `frame_start` at the next (0,0).
  - Blanking overrides tile colour even when the pipe carries stale data.
- Reset mid-frame: all counters and pipes clear asynchronously. After release, timing restarts at (0,0) with `hsync`/`vsync` high.

## Test plan
- Reset and idle:
  - Assert `reset`=0 mid-line → all outputs at reset values immediately.
  - Release → first `frame_start` 2 clk + 4 clk pipe after release.
- Sync timing:
  - Measure `hsync` → low 192 clk, period 1600 clk.
  - Measure `vsync` → low 3200 clk, period 840 000 clk.
- Addressing:
  - At tick (h=8, v=8) `char_addr`=81.
  - At (639,479) `char_addr`=4799.
  - No `char_addr` change during blanking.
- Glyph render:
  - Setup: tile 0x2741 at address 0; font model returns 0x81 for {0x41, row 0}.
  - Line 0, px 0 and 7 → `rgb`=3'b111.
  - px 1..6 → `rgb`=3'b010.
  - Blank region → 0.
- Blink: tile 0xA4FF with font 0xFF.
  - Frames 0–31 → `rgb`=3'b100.
  - Frames 32–63 → `rgb`=3'b010.
- Pipeline alignment:
  - Random tiles and font.
  - Reference model comparing `rgb`/`hsync`/`vsync` with a 4-clk delay over 2 full frames → zero mismatches.
